// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared watch types: alarm state encoding and time field limits
package watch_pkg;

    localparam int TIME_W   = 6;
    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_RINGING = 2'b10,
        ST_SNOOZE  = 2'b11
    } alarm_state_e;

endpackage

// File: rtl/alarm_ringer_btn_edge.sv
// rtl/alarm_ringer_btn_edge.sv - rising-edge detector for a debounced button level
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - alarm match, 1 s beep ringing, stop, bounded snooze and ring timeout
module alarm_ringer
    import watch_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3,
    parameter int CNT_W       = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic [TIME_W-1:0] cur_hour,
    input  logic [TIME_W-1:0] cur_min,
    input  logic [TIME_W-1:0] cur_sec,
    input  logic [TIME_W-1:0] alm_hour,
    input  logic [TIME_W-1:0] alm_min,
    input  logic              alarm_en,
    input  logic              aclear,
    input  logic              snooze,
    output logic              ring,
    output logic              buzz,
    output logic              snoozing,
    output logic [1:0]        snooze_left,
    output logic [1:0]        ST
);

    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNOOZE_SECS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [1:0]       SL_INIT   = 2'(MAX_SNOOZE);

    if (RING_SECS < 1 || SNOOZE_SECS < 1 || MAX_SNOOZE < 0 || MAX_SNOOZE > 3 ||
        RING_SECS > (2 ** CNT_W) - 1 || SNOOZE_SECS > (2 ** CNT_W) - 1) begin : g_param_check
        $error("alarm_ringer: CNT_W too narrow or parameter out of range");
    end

    alarm_state_e      state_q;
    logic [CNT_W-1:0]  ring_cnt_q;
    logic [CNT_W-1:0]  snz_cnt_q;
    logic              beep_q;
    logic              tick_d_q;
    logic              aclear_p_q;
    logic              snooze_p_q;
    logic [1:0]        snooze_left_q;
    logic              aclear_rise;
    logic              snooze_rise;
    logic              match;

    btn_edge u_aclear_edge (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (aclear),
        .rise_o (aclear_rise)
    );

    btn_edge u_snooze_edge (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (snooze),
        .rise_o (snooze_rise)
    );

    // cur_* is sampled the cycle after the tick, once the timekeeper has advanced
    assign match = tick_d_q && (cur_hour == alm_hour) && (cur_min == alm_min) &&
                   (cur_sec == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            ring_cnt_q    <= '0;
            snz_cnt_q     <= '0;
            beep_q        <= 1'b0;
            tick_d_q      <= 1'b0;
            aclear_p_q    <= 1'b0;
            snooze_p_q    <= 1'b0;
            snooze_left_q <= SL_INIT;
        end else begin
            tick_d_q   <= tick_1hz;
            aclear_p_q <= aclear_rise;
            snooze_p_q <= snooze_rise;
            if (!alarm_en) begin
                state_q       <= ST_IDLE;
                ring_cnt_q    <= '0;
                snz_cnt_q     <= '0;
                beep_q        <= 1'b0;
                snooze_left_q <= SL_INIT;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_ARMED;
                    ST_ARMED: begin
                        if (match) begin
                            state_q       <= ST_RINGING;
                            ring_cnt_q    <= '0;
                            beep_q        <= 1'b1;
                            snooze_left_q <= SL_INIT;
                        end
                    end
                    ST_RINGING: begin
                        if (aclear_p_q) begin
                            state_q <= ST_ARMED;
                        end else if (snooze_p_q) begin
                            if (snooze_left_q != 2'd0) begin
                                state_q       <= ST_SNOOZE;
                                snz_cnt_q     <= '0;
                                snooze_left_q <= snooze_left_q - 2'd1;
                            end else begin
                                state_q <= ST_ARMED;
                            end
                        end else if (tick_d_q) begin
                            beep_q <= ~beep_q;
                            if (ring_cnt_q == RING_LAST) begin
                                state_q <= ST_ARMED;
                            end else if (ring_cnt_q != CNT_MAX) begin
                                ring_cnt_q <= ring_cnt_q + 1'b1;
                            end
                        end
                    end
                    ST_SNOOZE: begin
                        // a second snooze while already snoozing is deliberately a no-op
                        if (aclear_p_q) begin
                            state_q <= ST_ARMED;
                        end else if (!snooze_p_q && tick_d_q) begin
                            if (snz_cnt_q == SNZ_LAST) begin
                                state_q    <= ST_RINGING;
                                ring_cnt_q <= '0;
                                beep_q     <= 1'b1;
                            end else if (snz_cnt_q != CNT_MAX) begin
                                snz_cnt_q <= snz_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign ring        = (state_q == ST_RINGING);
    assign buzz        = ring & beep_q;
    assign snoozing    = (state_q == ST_SNOOZE);
    assign snooze_left = snooze_left_q;
    assign ST          = state_q;

endmodule
